// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the UART buffer blocks: issue FSM encoding and FIFO depth checking.
// No logic here; reusable by a matching receive-side buffer.
package uart_tx_buffer_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] SEND_ENC = 2'd1;
  localparam logic [1:0] WAIT_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_SEND = SEND_ENC,
    ST_WAIT = WAIT_ENC
  } tx_state_e;

  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  localparam int unsigned DEFAULT_DEPTH    = 16;
  localparam bit          DEFAULT_DEPTH_OK = is_pow2(DEFAULT_DEPTH);

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Single-clock byte FIFO with occupancy count and an overflow pulse; 1-cycle write-to-visible latency.
// Pushes are refused while full (no same-cycle pop credit); rd_data is the head entry, combinational.
module sync_fifo
  import uart_tx_buffer_pkg::*;
#(
  parameter  int DATAWIDTH = 8,
  parameter  int DEPTH     = DEFAULT_DEPTH,
  localparam int ADDRW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDRW:0]       count,
  output logic                 overflow
);

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  localparam logic [ADDRW:0] FULL_CNT = (ADDRW + 1)'(DEPTH);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [ADDRW:0]       wr_ptr_q;
  logic [ADDRW:0]       rd_ptr_q;
  logic [ADDRW:0]       count_q;
  logic                 overflow_q;
  logic                 push;
  logic                 pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = mem[rd_ptr_q[ADDRW-1:0]];

  // A flush cycle swallows any push so the FIFO is guaranteed empty afterwards.
  assign push = wr_en && !full && !flush;
  assign pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[ADDRW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr_en && full;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers host bytes and issues them one at a time to the UART transmitter; push-to-valid is 2 edges.
// Holds tx_data_valid until the UART reports busy, then waits for tx_done or busy low before the next byte.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter  int DATAWIDTH = 8,
  parameter  int DEPTH     = DEFAULT_DEPTH,
  localparam int ADDRW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDRW:0]       count,
  output logic                 overflow,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 tx_data_valid,
  output logic [DATAWIDTH-1:0] tx_in
);

  tx_state_e            state_q;
  tx_state_e            state_d;
  logic                 valid_d;
  logic                 pop;
  logic [DATAWIDTH-1:0] head;

  sync_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_comb begin
    state_d = state_q;
    valid_d = tx_data_valid;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // The UART only samples on its baud tick, so valid stays up until it shows busy.
        if (tx_busy) begin
          valid_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done || !tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      tx_data_valid <= 1'b0;
      tx_in         <= '0;
    end else begin
      state_q       <= state_d;
      tx_data_valid <= valid_d;
      if (pop) begin
        tx_in <= head;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: the UART side is driven by hand through tx_busy/tx_done.
module tb_uart_tx_buffer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_data_valid;
  logic [7:0] tx_in;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_buffer #(.DATAWIDTH(8), .DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_data_valid (tx_data_valid),
    .tx_in         (tx_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Let the buffer issue one byte, check it, then complete the UART handshake.
  task automatic serve(input logic [7:0] exp);
    int n;
    n = 0;
    tx_busy = 1'b0;
    while (!tx_data_valid && n < 20) begin
      tick();
      n++;
    end
    chk("serve_valid", 32'(tx_data_valid), 32'd1);
    chk("serve_data", 32'(tx_in), 32'(exp));
    tx_busy = 1'b1;
    tick();
    chk("serve_valid_drop", 32'(tx_data_valid), 32'd0);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    tx_busy = 1'b0; tx_done = 1'b0;
    tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_tx_in", 32'(tx_in), 32'd0);
    rst = 1'b1;
    tick();

    // Single byte into an idle UART: valid two edges after the push edge.
    push(8'hA5);
    chk("lat_count1", 32'(count), 32'd1);
    chk("lat_valid_early", 32'(tx_data_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(tx_data_valid), 32'd1);
    chk("lat_tx_in", 32'(tx_in), 32'hA5);
    chk("lat_empty", 32'(empty), 32'd1);
    tx_busy = 1'b1;
    tick();
    chk("lat_valid_drop", 32'(tx_data_valid), 32'd0);
    tx_busy = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("lat_empty_after", 32'(empty), 32'd1);

    // Fill while the UART is busy, then overflow.
    tx_busy = 1'b1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    chk("fill_no_valid", 32'(tx_data_valid), 32'd0);
    push(8'h11);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    tick();
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    for (int i = 1; i <= 16; i++) serve(8'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 5, then 40 bytes through the wrap.
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    chk("pp_count5", 32'(count), 32'd5);
    tx_busy = 1'b0;
    push(8'h25);
    chk("pp_count_hold", 32'(count), 32'd5);
    chk("pp_valid", 32'(tx_data_valid), 32'd1);
    chk("pp_tx_in", 32'(tx_in), 32'h20);
    serve(8'h20);
    for (int j = 1; j < 40; j++) begin
      tx_busy = 1'b1;
      if (j + 5 < 40) push(8'(8'h20 + j + 5));
      serve(8'(8'h20 + j));
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // tx_done with three bytes still queued.
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
    tx_busy = 1'b0;
    tick();
    chk("done_first", 32'(tx_in), 32'h50);
    chk("done_count3", 32'(count), 32'd3);
    tx_busy = 1'b1;
    tick(); tick(); tick();
    chk("done_wait_valid", 32'(tx_data_valid), 32'd0);
    chk("done_wait_count", 32'(count), 32'd3);
    tx_busy = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("done_exit_valid", 32'(tx_data_valid), 32'd0);
    tick();
    chk("done_next_valid", 32'(tx_data_valid), 32'd1);
    chk("done_next_data", 32'(tx_in), 32'h51);
    serve(8'h51);
    serve(8'h52);
    serve(8'h53);
    chk("done_empty", 32'(empty), 32'd1);

    // Flush during SEND: the in-flight byte survives, the queue does not.
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    tx_busy = 1'b0;
    tick();
    chk("fl_send", 32'(tx_in), 32'h60);
    chk("fl_count4", 32'(count), 32'd4);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_valid_held", 32'(tx_data_valid), 32'd1);
    chk("fl_data_held", 32'(tx_in), 32'h60);
    tx_busy = 1'b1;
    tick();
    chk("fl_valid_drop", 32'(tx_data_valid), 32'd0);
    tx_busy = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fl_no_more", 32'(tx_data_valid), 32'd0);
    end

    // Asynchronous reset in WAIT.
    tx_busy = 1'b1;
    push(8'h70);
    push(8'h71);
    tx_busy = 1'b0;
    tick();
    chk("ar_send", 32'(tx_in), 32'h70);
    tx_busy = 1'b1;
    tick();
    chk("ar_wait_valid", 32'(tx_data_valid), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("ar_tx_in", 32'(tx_in), 32'd0);
    chk("ar_valid", 32'(tx_data_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_full", 32'(full), 32'd0);
    tick();
    rst = 1'b1; tx_busy = 1'b0;
    tick(); tick();
    chk("ar_idle_after", 32'(tx_data_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
